e203_exu_wbck_arb: RTL and testbench
====================================

E203_EXU_WBCK_ARB -- requirements
Module: e203_exu_wbck_arb

Interface
REQ-001 Parameter NCH, default 3: number of write-back source channels (legal 2..8); channel NCH-1 has the highest static priority, channel 0 the lowest.
REQ-002 Parameter XLEN, default 32: integer write-back data width.
REQ-003 Parameter RFIDX_W, default 5: register index width.
REQ-004 Parameter STARVE_LIM, default 4: consecutive stalled-valid cycles before a channel is force-granted (legal 1..15).
REQ-005 clk  input  1  single clock, all state on its rising edge.
REQ-006 rst_n  input  1  asynchronous active-low reset.
REQ-007 wbck_i_valid  input  NCH  per-channel request valid.
REQ-008 wbck_i_ready  output  NCH  per-channel accept; the channel transfers when valid&ready.
REQ-009 wbck_i_wdat  input  NCH*XLEN  per-channel data; channel i occupies bits [i*XLEN +: XLEN].
REQ-010 wbck_i_rdidx  input  NCH*RFIDX_W  per-channel destination index, packed the same way.
REQ-011 wbck_i_rdfpu  input  NCH  per-channel flag: destination is the FP regfile.
REQ-012 wbck_o_ready  input  1  regfile port can absorb the held entry this cycle.
REQ-013 rf_wbck_o_ena  output  1  integer regfile write enable.
REQ-014 frf_wbck_o_ena  output  1  FP regfile write enable.
REQ-015 rf_wbck_o_wdat  output  XLEN  write data, shared by both enables.
REQ-016 rf_wbck_o_rdidx  output  RFIDX_W  write index, shared by both enables.

Function
REQ-017 The block SHALL hold the arbitration result in a one-entry output register (valid, wdat, rdidx, rdfpu); write-back latency is exactly 1 cycle from acceptance to output.
REQ-018 The block SHALL assert rf_wbck_o_ena = held_valid & ~held_rdfpu & wbck_o_ready, and frf_wbck_o_ena = held_valid & held_rdfpu & wbck_o_ready.
REQ-019 The stage SHALL be able to load when it is empty or when it is draining in the same cycle (held_valid & wbck_o_ready); in a load cycle the new entry replaces the drained entry with no bubble.
REQ-020 Exactly one channel SHALL be granted per load cycle: the highest-index valid channel, unless a starvation override applies (REQ-022).
REQ-021 wbck_i_ready[i] SHALL be 1 only for the granted channel in a load cycle; every other ready bit SHALL be 0; all ready bits SHALL be 0 when the stage cannot load.
REQ-022 Starvation override: when any channel's counter equals STARVE_LIM, the lowest-index such channel SHALL be granted instead of the static winner.
REQ-023 Each channel's counter SHALL increment when that channel is valid and not accepted, clear on acceptance or when the channel is not valid, and saturate at STARVE_LIM.
REQ-024 When no channel is valid and the stage drains, held_valid SHALL clear on the next edge.
REQ-025 The outputs rf_wbck_o_wdat/rdidx SHALL reflect the held register even when held_valid=0; consumers qualify them with the enables.

Reset
REQ-026 On rst_n low, held_valid, all counters, rf_wbck_o_ena and frf_wbck_o_ena SHALL be 0 immediately; held data and index SHALL reset to 0.
REQ-027 A reset asserted mid-transfer SHALL discard the held entry with no write pulse.

Configuration
REQ-028 Macro E203_WBCK_STARVE_GUARD_EN: when defined, REQ-022/023 are active; when undefined, no counters exist and arbitration is pure static priority (REQ-020 only).

Structure
REQ-029 The shared package e203_wbck_pkg SHALL hold the default parameter constants and the packed write-back entry typedef {rdfpu, rdidx, wdat}.
REQ-030 One sub-module, e203_wbck_starve_cnt, SHALL implement a single saturating per-channel counter and be instantiated NCH-1 times (channel NCH-1 never starves).

Verification
REQ-031 NCH=3, ch0 and ch2 valid, wbck_o_ready=1 -> ch2 granted; next cycle rf_wbck_o_ena=1 with ch2 wdat/rdidx.
REQ-032 ch2 valid continuously, ch0 valid, STARVE_LIM=4, guard enabled -> ch0 accepted in its 5th valid cycle; with guard disabled ch0 is never accepted.
REQ-033 Held entry, wbck_o_ready=0 for 3 cycles -> all wbck_i_ready=0, outputs stable, no enable pulse; ready=1 -> one write, new entry loaded in the same cycle.
REQ-034 ch1 rdfpu=1, rdidx=5, wdat=0x3F800000 -> frf_wbck_o_ena=1, rf_wbck_o_ena=0 one cycle later.
REQ-035 rst_n low while entry held and wbck_o_ready=0 -> both enables 0 immediately, no write after release.
REQ-036 Back-to-back single-channel traffic, 10 transfers with wbck_o_ready=1 -> 10 consecutive write cycles, no bubble.

Source files
------------

// File: rtl/e203_wbck_pkg.sv
// Shared constants and the write-back entry type for the EXU write-back arbiter.
// Used by e203_exu_wbck_arb and its starvation counter.
package e203_wbck_pkg;

    localparam int NCH_DEF        = 3;
    localparam int XLEN_DEF       = 32;
    localparam int RFIDX_W_DEF    = 5;
    localparam int STARVE_LIM_DEF = 4;
    localparam int CNT_W          = 4;

    typedef struct packed {
        logic                   rdfpu;
        logic [RFIDX_W_DEF-1:0] rdidx;
        logic [XLEN_DEF-1:0]    wdat;
    } wbck_entry_t;

endpackage

// File: rtl/e203_exu_wbck_arb_if.sv
// Write-back bundle: NCH source channels in, one regfile port out.
// master drives the sources and the regfile ready; slave is the arbiter.
interface e203_exu_wbck_arb_if
    import e203_wbck_pkg::*;
#(
    parameter int NCH     = NCH_DEF,
    parameter int XLEN    = XLEN_DEF,
    parameter int RFIDX_W = RFIDX_W_DEF
);

    logic [NCH-1:0]         wbck_i_valid;
    logic [NCH-1:0]         wbck_i_ready;
    logic [NCH*XLEN-1:0]    wbck_i_wdat;
    logic [NCH*RFIDX_W-1:0] wbck_i_rdidx;
    logic [NCH-1:0]         wbck_i_rdfpu;
    logic                   wbck_o_ready;
    logic                   rf_wbck_o_ena;
    logic                   frf_wbck_o_ena;
    logic [XLEN-1:0]        rf_wbck_o_wdat;
    logic [RFIDX_W-1:0]     rf_wbck_o_rdidx;

    modport master (
        output wbck_i_valid,
        output wbck_i_wdat,
        output wbck_i_rdidx,
        output wbck_i_rdfpu,
        output wbck_o_ready,
        input  wbck_i_ready,
        input  rf_wbck_o_ena,
        input  frf_wbck_o_ena,
        input  rf_wbck_o_wdat,
        input  rf_wbck_o_rdidx
    );

    modport slave (
        input  wbck_i_valid,
        input  wbck_i_wdat,
        input  wbck_i_rdidx,
        input  wbck_i_rdfpu,
        input  wbck_o_ready,
        output wbck_i_ready,
        output rf_wbck_o_ena,
        output frf_wbck_o_ena,
        output rf_wbck_o_wdat,
        output rf_wbck_o_rdidx
    );

endinterface

// File: rtl/e203_wbck_starve_cnt.sv
// Saturating count of consecutive cycles a channel waited with valid high.
// hit flags that the channel has waited LIM cycles and must be force-granted.
module e203_wbck_starve_cnt
    import e203_wbck_pkg::*;
#(
    parameter int LIM = STARVE_LIM_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic valid,
    input  logic accept,
    output logic hit
);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (!valid || accept) begin
            cnt <= '0;
        end else if (cnt != CNT_W'(LIM)) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign hit = (cnt == CNT_W'(LIM));

endmodule

// File: rtl/e203_exu_wbck_arb.sv
// EXU write-back arbiter: static priority (highest index wins) into a 1-entry
// output register. Define E203_WBCK_STARVE_GUARD_EN to add starvation override.
module e203_exu_wbck_arb
    import e203_wbck_pkg::*;
#(
    parameter int NCH        = NCH_DEF,
    parameter int XLEN       = XLEN_DEF,
    parameter int RFIDX_W    = RFIDX_W_DEF,
    parameter int STARVE_LIM = STARVE_LIM_DEF
) (
    input  logic                clk,
    input  logic                rst_n,
    e203_exu_wbck_arb_if.slave  bus
);

    typedef struct packed {
        logic               rdfpu;
        logic [RFIDX_W-1:0] rdidx;
        logic [XLEN-1:0]    wdat;
    } entry_t;

    logic           held_valid;
    entry_t         held;
    entry_t         nxt;
    logic           load;
    logic [NCH-1:0] static_gnt;
    logic [NCH-1:0] gnt;
    logic [NCH-1:0] acc;

    // A draining entry frees the slot in the same cycle, so no bubble.
    assign load = ~held_valid | bus.wbck_o_ready;

    always_comb begin
        static_gnt = '0;
        for (int i = 0; i < NCH; i++) begin
            if (bus.wbck_i_valid[i]) static_gnt = NCH'(1) << i;
        end
    end

`ifdef E203_WBCK_STARVE_GUARD_EN
    logic [NCH-2:0] hit;

    // Scan downward so the lowest starving channel ends up granted.
    always_comb begin
        gnt = static_gnt;
        for (int i = NCH - 2; i >= 0; i--) begin
            if (hit[i] && bus.wbck_i_valid[i]) gnt = NCH'(1) << i;
        end
    end

    for (genvar g = 0; g < NCH - 1; g++) begin : g_cnt
        e203_wbck_starve_cnt #(
            .LIM (STARVE_LIM)
        ) u_cnt (
            .clk    (clk),
            .rst_n  (rst_n),
            .valid  (bus.wbck_i_valid[g]),
            .accept (acc[g]),
            .hit    (hit[g])
        );
    end
`else
    logic unused_lim;
    assign unused_lim = (STARVE_LIM > 0);
    assign gnt        = static_gnt;
`endif

    assign acc              = gnt & {NCH{load}};
    assign bus.wbck_i_ready = acc;

    always_comb begin
        nxt = '0;
        for (int i = 0; i < NCH; i++) begin
            if (gnt[i]) begin
                nxt.rdfpu = bus.wbck_i_rdfpu[i];
                nxt.rdidx = bus.wbck_i_rdidx[i*RFIDX_W +: RFIDX_W];
                nxt.wdat  = bus.wbck_i_wdat[i*XLEN +: XLEN];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            held_valid <= 1'b0;
            held       <= '0;
        end else if (load) begin
            held_valid <= |bus.wbck_i_valid;
            if (|bus.wbck_i_valid) held <= nxt;
        end
    end

    assign bus.rf_wbck_o_ena   = held_valid & ~held.rdfpu & bus.wbck_o_ready;
    assign bus.frf_wbck_o_ena  = held_valid &  held.rdfpu & bus.wbck_o_ready;
    assign bus.rf_wbck_o_wdat  = held.wdat;
    assign bus.rf_wbck_o_rdidx = held.rdidx;

endmodule

// File: tb/tb_e203_exu_wbck_arb.sv
// Bench for e203_exu_wbck_arb: directed scenarios plus random traffic
// checked against a cycle model of the arbitration rules.
module tb_e203_exu_wbck_arb;
    import e203_wbck_pkg::*;

    localparam int NCH = 3;
    localparam int XL  = 32;
    localparam int RW  = 5;
    localparam int LIM = 4;
`ifdef E203_WBCK_STARVE_GUARD_EN
    localparam bit GUARD = 1'b1;
`else
    localparam bit GUARD = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    e203_exu_wbck_arb_if #(.NCH(NCH), .XLEN(XL), .RFIDX_W(RW)) bus ();

    e203_exu_wbck_arb #(
        .NCH(NCH), .XLEN(XL), .RFIDX_W(RW), .STARVE_LIM(LIM)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_vec = 0;
    int n_err = 0;

    // model state
    bit             m_hv;
    logic [XL-1:0]  m_wdat;
    logic [RW-1:0]  m_idx;
    bit             m_fpu;
    int             m_stall [NCH];
    bit             e_load;
    int             e_win;
    logic [NCH-1:0] e_ready;
    bit             e_rf;
    bit             e_frf;

    task automatic model_reset();
        m_hv = 0; m_wdat = '0; m_idx = '0; m_fpu = 0;
        for (int i = 0; i < NCH; i++) m_stall[i] = 0;
    endtask

    task automatic model_eval();
        e_load = !m_hv || bus.wbck_o_ready;
        e_win  = -1;
        for (int i = 0; i < NCH; i++)
            if (bus.wbck_i_valid[i]) e_win = i;
        if (GUARD)
            for (int i = NCH - 2; i >= 0; i--)
                if (bus.wbck_i_valid[i] && m_stall[i] >= LIM) e_win = i;
        e_ready = '0;
        if (e_load && e_win >= 0) e_ready[e_win] = 1'b1;
        e_rf  = m_hv && !m_fpu && bus.wbck_o_ready;
        e_frf = m_hv &&  m_fpu && bus.wbck_o_ready;
    endtask

    task automatic model_tick();
        for (int i = 0; i < NCH; i++) begin
            if (bus.wbck_i_valid[i] && !e_ready[i])
                m_stall[i] = (m_stall[i] < LIM) ? m_stall[i] + 1 : LIM;
            else
                m_stall[i] = 0;
        end
        if (e_load) begin
            m_hv = (e_win >= 0);
            if (e_win >= 0) begin
                m_wdat = bus.wbck_i_wdat[e_win*XL +: XL];
                m_idx  = bus.wbck_i_rdidx[e_win*RW +: RW];
                m_fpu  = bus.wbck_i_rdfpu[e_win];
            end
        end
    endtask

    task automatic settle();
        @(negedge clk);
        model_eval();
    endtask

    task automatic advance();
        @(posedge clk);
        model_tick();
        #1;
    endtask

    task automatic set_ch(input int c, input logic [XL-1:0] d,
                          input logic [RW-1:0] r, input bit f);
        bus.wbck_i_wdat[c*XL +: XL]  = d;
        bus.wbck_i_rdidx[c*RW +: RW] = r;
        bus.wbck_i_rdfpu[c]          = f;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.wbck_i_valid = '0;
        bus.wbck_i_wdat  = '0;
        bus.wbck_i_rdidx = '0;
        bus.wbck_i_rdfpu = '0;
        bus.wbck_o_ready = 1'b1;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        n_vec++;
        if (bus.rf_wbck_o_ena !== 1'b0 || bus.frf_wbck_o_ena !== 1'b0) begin
            n_err++;
            $display("FAIL reset_ena got %b/%b want 0/0",
                     bus.rf_wbck_o_ena, bus.frf_wbck_o_ena);
        end
        n_vec++;
        if (bus.rf_wbck_o_wdat !== '0 || bus.rf_wbck_o_rdidx !== '0) begin
            n_err++;
            $display("FAIL reset_data got %h/%h want 0/0",
                     bus.rf_wbck_o_wdat, bus.rf_wbck_o_rdidx);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_priority();
        bus.wbck_o_ready = 1'b1;
        set_ch(0, 32'h1111_0000, 5'd3, 1'b0);
        set_ch(2, 32'hCAFE_0002, 5'd17, 1'b0);
        bus.wbck_i_valid = 3'b101;
        settle();
        n_vec++;
        if (bus.wbck_i_ready !== 3'b100) begin
            n_err++;
            $display("FAIL prio_ready got %b want 100", bus.wbck_i_ready);
        end
        advance();
        bus.wbck_i_valid = '0;
        settle();
        n_vec++;
        if (bus.rf_wbck_o_ena !== 1'b1 ||
            bus.rf_wbck_o_wdat !== 32'hCAFE_0002 ||
            bus.rf_wbck_o_rdidx !== 5'd17) begin
            n_err++;
            $display("FAIL prio_write got %b %h %0d want 1 cafe0002 17",
                     bus.rf_wbck_o_ena, bus.rf_wbck_o_wdat,
                     bus.rf_wbck_o_rdidx);
        end
        advance();
        advance();
    endtask

    task automatic test_starve();
        int first;
        first = 0;
        bus.wbck_o_ready = 1'b1;
        bus.wbck_i_valid = '0;
        advance();
        bus.wbck_i_valid = 3'b101;
        for (int n = 1; n <= 12; n++) begin
            set_ch(0, $urandom, 5'($urandom), 1'b0);
            set_ch(2, $urandom, 5'($urandom), 1'b0);
            settle();
            n_vec++;
            if (bus.wbck_i_ready !== e_ready) begin
                n_err++;
                $display("FAIL starve_ready cyc %0d got %b want %b",
                         n, bus.wbck_i_ready, e_ready);
            end
            if (first == 0 && bus.wbck_i_ready[0]) first = n;
            advance();
        end
        n_vec++;
        if (first != (GUARD ? LIM + 1 : 0)) begin
            n_err++;
            $display("FAIL starve_first got %0d want %0d",
                     first, GUARD ? LIM + 1 : 0);
        end
        bus.wbck_i_valid = '0;
        advance();
        advance();
    endtask

    task automatic test_stall();
        logic [XL-1:0] hold_d;
        bus.wbck_o_ready = 1'b1;
        set_ch(1, 32'h0BAD_F00D, 5'd9, 1'b0);
        bus.wbck_i_valid = 3'b010;
        advance();
        hold_d = 32'h0BAD_F00D;
        bus.wbck_o_ready = 1'b0;
        set_ch(0, 32'h0000_AAAA, 5'd1, 1'b0);
        set_ch(2, 32'h2222_BBBB, 5'd22, 1'b0);
        bus.wbck_i_valid = 3'b111;
        for (int n = 0; n < 3; n++) begin
            settle();
            n_vec++;
            if (bus.wbck_i_ready !== 3'b000 || bus.rf_wbck_o_ena !== 1'b0 ||
                bus.frf_wbck_o_ena !== 1'b0) begin
                n_err++;
                $display("FAIL stall_hold got rdy %b ena %b/%b want 000 0/0",
                         bus.wbck_i_ready, bus.rf_wbck_o_ena,
                         bus.frf_wbck_o_ena);
            end
            n_vec++;
            if (bus.rf_wbck_o_wdat !== hold_d) begin
                n_err++;
                $display("FAIL stall_data got %h want %h",
                         bus.rf_wbck_o_wdat, hold_d);
            end
            advance();
        end
        bus.wbck_o_ready = 1'b1;
        settle();
        n_vec++;
        if (bus.rf_wbck_o_ena !== 1'b1 || bus.wbck_i_ready !== e_ready) begin
            n_err++;
            $display("FAIL stall_release got ena %b rdy %b want 1 %b",
                     bus.rf_wbck_o_ena, bus.wbck_i_ready, e_ready);
        end
        advance();
        bus.wbck_i_valid = '0;
        settle();
        n_vec++;
        if (bus.rf_wbck_o_wdat !== 32'h2222_BBBB) begin
            n_err++;
            $display("FAIL stall_newload got %h want 2222bbbb",
                     bus.rf_wbck_o_wdat);
        end
        advance();
        advance();
    endtask

    task automatic test_fpu();
        bus.wbck_o_ready = 1'b1;
        set_ch(1, 32'h3F80_0000, 5'd5, 1'b1);
        bus.wbck_i_valid = 3'b010;
        advance();
        bus.wbck_i_valid = '0;
        settle();
        n_vec++;
        if (bus.frf_wbck_o_ena !== 1'b1 || bus.rf_wbck_o_ena !== 1'b0) begin
            n_err++;
            $display("FAIL fpu_ena got frf %b rf %b want 1 0",
                     bus.frf_wbck_o_ena, bus.rf_wbck_o_ena);
        end
        n_vec++;
        if (bus.rf_wbck_o_wdat !== 32'h3F80_0000 ||
            bus.rf_wbck_o_rdidx !== 5'd5) begin
            n_err++;
            $display("FAIL fpu_data got %h/%0d want 3f800000/5",
                     bus.rf_wbck_o_wdat, bus.rf_wbck_o_rdidx);
        end
        advance();
        set_ch(1, '0, '0, 1'b0);
    endtask

    task automatic test_reset_mid();
        bus.wbck_o_ready = 1'b1;
        set_ch(2, 32'h7777_0007, 5'd7, 1'b0);
        bus.wbck_i_valid = 3'b100;
        advance();
        bus.wbck_i_valid = '0;
        bus.wbck_o_ready = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        bus.wbck_o_ready = 1'b1;
        #1;
        n_vec++;
        if (bus.rf_wbck_o_ena !== 1'b0 || bus.frf_wbck_o_ena !== 1'b0) begin
            n_err++;
            $display("FAIL rstmid_ena got %b/%b want 0/0",
                     bus.rf_wbck_o_ena, bus.frf_wbck_o_ena);
        end
        n_vec++;
        if (bus.rf_wbck_o_wdat !== '0) begin
            n_err++;
            $display("FAIL rstmid_data got %h want 0", bus.rf_wbck_o_wdat);
        end
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        for (int n = 0; n < 3; n++) begin
            settle();
            n_vec++;
            if (bus.rf_wbck_o_ena !== 1'b0 || bus.frf_wbck_o_ena !== 1'b0) begin
                n_err++;
                $display("FAIL rstmid_after cyc %0d got %b/%b want 0/0",
                         n, bus.rf_wbck_o_ena, bus.frf_wbck_o_ena);
            end
            advance();
        end
    endtask

    task automatic test_back_to_back();
        logic [XL-1:0] sent [$];
        int writes;
        writes = 0;
        bus.wbck_o_ready = 1'b1;
        for (int k = 0; k <= 10; k++) begin
            if (k < 10) begin
                set_ch(0, $urandom, 5'(k), 1'b0);
                sent.push_back(bus.wbck_i_wdat[0 +: XL]);
                bus.wbck_i_valid = 3'b001;
            end else begin
                bus.wbck_i_valid = '0;
            end
            settle();
            if (k > 0) begin
                n_vec++;
                if (bus.rf_wbck_o_ena !== 1'b1 ||
                    bus.rf_wbck_o_wdat !== sent[k-1]) begin
                    n_err++;
                    $display("FAIL b2b_write %0d got %b %h want 1 %h",
                             k, bus.rf_wbck_o_ena, bus.rf_wbck_o_wdat,
                             sent[k-1]);
                end
                if (bus.rf_wbck_o_ena === 1'b1) writes++;
            end
            advance();
        end
        n_vec++;
        if (writes != 10) begin
            n_err++;
            $display("FAIL b2b_count got %0d want 10", writes);
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            bus.wbck_i_valid = NCH'($urandom);
            bus.wbck_o_ready = ($urandom_range(0, 9) < 7);
            for (int c = 0; c < NCH; c++)
                set_ch(c, $urandom, 5'($urandom), 1'($urandom));
            settle();
            n_vec++;
            if (bus.wbck_i_ready !== e_ready) begin
                n_err++;
                $display("FAIL rnd_ready cyc %0d got %b want %b",
                         n, bus.wbck_i_ready, e_ready);
            end
            n_vec++;
            if (bus.rf_wbck_o_ena !== e_rf || bus.frf_wbck_o_ena !== e_frf) begin
                n_err++;
                $display("FAIL rnd_ena cyc %0d got %b/%b want %b/%b", n,
                         bus.rf_wbck_o_ena, bus.frf_wbck_o_ena, e_rf, e_frf);
            end
            n_vec++;
            if (bus.rf_wbck_o_wdat !== m_wdat || bus.rf_wbck_o_rdidx !== m_idx) begin
                n_err++;
                $display("FAIL rnd_data cyc %0d got %h/%0d want %h/%0d", n,
                         bus.rf_wbck_o_wdat, bus.rf_wbck_o_rdidx, m_wdat, m_idx);
            end
            advance();
        end
    endtask

    initial begin
        test_reset();
        test_priority();
        test_starve();
        test_stall();
        test_fpu();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got running want finished");
        $fatal(1, "timeout");
    end

endmodule
